// File: rtl/button_evt_pkg.sv
// Shared definitions for the button event arbiter: FSM state encoding,
// default button count and overrun counter sizing.
package button_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam int NUM_BTN_DEF = 4;

  // Overrun counter width and the value it sticks at.
  localparam int              OVR_W   = 8;
  localparam logic [OVR_W-1:0] OVR_SAT = 8'hFF;

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches the request vector
// upward starting one past the last grant, wrapping at NUM_BTN-1 -> 0.
module rr_pick #(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  // First set request after ptr, in wrapped order; ptr itself is checked last.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] sel;
    gnt_id = '0;
    found  = 1'b0;
    sel    = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      sel = ID_W'((int'(ptr) + k) % NUM_BTN);
      if (!found && req[sel]) begin
        found  = 1'b1;
        gnt_id = sel;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: latches one-cycle button press pulses as pending
// events and offers them one at a time over evt_valid/evt_ready, picking
// among pending buttons round-robin. Outputs are fully registered.
// Optional feature: define BTN_OVERRUN_CNT_EN to add the saturating
// overrun_cnt port counting edges on which a press was dropped.
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_BTN-1:0] pending
`ifdef BTN_OVERRUN_CNT_EN
  ,
  output logic [OVR_W-1:0]   overrun_cnt
`endif
);

  arb_state_e          state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic                evt_valid_nxt;
  logic [ID_W-1:0]     evt_id_nxt;
  logic [ID_W-1:0]     gnt_id;
  logic                any_req;
  logic                xfer;
  logic [NUM_BTN-1:0]  clr;

  assign xfer = evt_valid & evt_ready;

  // One-hot clear of the pending bit whose event is handed over this edge.
  always_comb begin
    clr = '0;
    if (xfer) clr[evt_id] = 1'b1;
  end

  rr_pick #(
    .NUM_BTN (NUM_BTN),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (pending),
    .ptr     (ptr),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  // Pending register: clear on transfer, then set on press, so a press in the
  // transfer cycle re-arms the bit as a fresh event.
  always_ff @(posedge clk) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr) | btn_pulse;
  end

  // FSM and registered output state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_BTN - 1);
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      evt_valid <= evt_valid_nxt;
      evt_id    <= evt_id_nxt;
    end
  end

  // Next state: arbitrate only from IDLE; hold the offer until accepted.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    evt_valid_nxt = evt_valid;
    evt_id_nxt    = evt_id;
    unique case (state)
      IDLE: begin
        evt_valid_nxt = 1'b0;
        if (any_req) begin
          state_nxt     = OFFER;
          evt_valid_nxt = 1'b1;
          evt_id_nxt    = gnt_id;
          ptr_nxt       = gnt_id;
        end
      end
      OFFER: begin
        evt_valid_nxt = 1'b1;
        if (evt_ready) begin
          state_nxt     = IDLE;
          evt_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        evt_valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef BTN_OVERRUN_CNT_EN
  logic [NUM_BTN-1:0] drop;

  // A press on a bit that stays pending through this edge is lost.
  assign drop = btn_pulse & pending & ~clr;

  // Count edges with any drop (not drops), sticking at saturation.
  always_ff @(posedge clk) begin
    if (!rst)                             overrun_cnt <= '0;
    else if (|drop && overrun_cnt != OVR_SAT) overrun_cnt <= overrun_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle press pulses from the per-button shapers, holds each as a pending event, and hands them one at a time to the LED matrix command logic over a valid/ready handshake. Round-robin arbitration keeps simultaneous or back-to-back presses from being lost or starving a button. It sits between the button shaper bank and the matrix controller's command input.

## Interface
- NUM_BTN, 4, number of button pulse inputs (2..16)
- ID_W, 2, width of event ID; must equal ceil(log2(NUM_BTN))
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- btn_pulse  in  NUM_BTN  one-cycle press pulses, bit i = button i
- evt_valid  out  1  event offered downstream
- evt_id  out  ID_W  index of button whose event is offered
- evt_ready  in  1  downstream accepts event this cycle
- pending  out  NUM_BTN  registered pending-event bits
- overrun_cnt  out  8  dropped-event count (only with BTN_OVERRUN_CNT_EN)

## Operation
- Reset values: pending=0, evt_valid=0, evt_id=0, last-grant pointer=NUM_BTN-1 (first search starts at button 0), overrun_cnt=0, state IDLE.
- Pending bit i: set on edge where btn_pulse[i]=1; cleared on edge where event i is transferred (evt_valid & evt_ready & evt_id==i). Pulse and clear of same bit on same edge -> bit remains set (new press becomes a fresh event).
- Pulse on bit already pending and not being cleared that edge -> event dropped (one event per button outstanding max).
- States: IDLE, OFFER.
  - IDLE: if pending!=0, select first set bit searching upward from pointer+1, wrapping at NUM_BTN-1 -> 0; register evt_id=selection, evt_valid=1, pointer=selection, go OFFER. Else stay, evt_valid=0.
  - OFFER: evt_valid=1, evt_id stable. On evt_ready=1: transfer, evt_valid=0 next cycle, go IDLE. On evt_ready=0: hold.
- Arbitration decided only in IDLE; events arriving during OFFER wait.
- evt_ready while evt_valid=0 ignored.

## Timing
- Pulse in cycle n -> pending visible cycle n+1 -> evt_valid=1 cycle n+2 (2-cycle latency from idle).
- Transfer at edge ending cycle m -> evt_valid=0 cycle m+1 (one bubble) -> next event valid cycle m+2. Max throughput one event per 2 cycles.
- evt_id and evt_valid registered; no combinational path from evt_ready or btn_pulse to outputs.
- rst=0 mid-OFFER: next cycle evt_valid=0, all pending cleared, offered event lost; btn_pulse during reset ignored.

## Configuration
- BTN_OVERRUN_CNT_EN defined: overrun_cnt port present; increments by 1 per edge on which at least one pulse is dropped (multiple drops same edge count once), saturates at 255, cleared only by reset.
- Not defined: port and counter absent; drops silent; all other behaviour identical.

## Structure
- Shared package button_evt_pkg: state encoding constants (IDLE=0, OFFER=1), default NUM_BTN, overrun counter width (8) and saturation value.
- One sub-module: rr_pick, combinational round-robin picker (inputs request vector, pointer; outputs grant index, any-request flag). Arbiter FSM, pending register and counter stay in top.

## Test plan
- Single press: btn_pulse=4'b0100 cycle 0, evt_ready=1 -> evt_valid=1 evt_id=2 in cycle 2, pending=0 cycle 3, evt_valid=0 cycle 3.
- Simultaneous: btn_pulse=4'b1111 one cycle, evt_ready=1 -> ids 0,1,2,3 in order, valid cycles 2,4,6,8.
- Fairness: after grant of id 1, pending=4'b0011 -> next grant id 0 via wrap; with pending=4'b1011 -> next grant id 3.
- Backpressure: evt_ready=0 for 10 cycles with id 2 offered -> evt_valid and evt_id=2 held; second pulse on button 2 dropped, overrun_cnt=1 (macro on); pulse on button 2 in transfer cycle -> pending[2] stays 1, id 2 offered again.
- Reset mid-OFFER: rst=0 one cycle while evt_valid=1, pending=4'b1010 -> next cycle evt_valid=0, pending=0, overrun_cnt=0; next press on button 3 granted first-search from 0 -> id 3.
